// File: rtl/perf_pkg.sv
// Shared types and sizing for the performance counter block.
package perf_pkg;

  localparam int unsigned PERF_CNT_W      = 32;
  localparam int unsigned PERF_NUM_CNT    = 8;
  localparam int unsigned PERF_IDX_W      = 3;
  localparam int unsigned PERF_WINDOW_TOP = 32;

  // Counter word index within the window (addr[4:2]).
  typedef enum logic [PERF_IDX_W-1:0] {
    PERF_IDX_NUM_INSTR_ACCESS = 3'd0,
    PERF_IDX_NUM_DATA_ACCESS  = 3'd1,
    PERF_IDX_NUM_L1_ACCESS    = 3'd2,
    PERF_IDX_INSTR_CYCLES     = 3'd3,
    PERF_IDX_DATA_CYCLES      = 3'd4,
    PERF_IDX_L1_CYCLES        = 3'd5,
    PERF_IDX_NUM_PREDICTIONS  = 3'd6,
    PERF_IDX_NUM_CORRECT      = 3'd7
  } perf_idx_t;

  // Per-channel handshake tracking state.
  typedef enum logic {
    PERF_IDLE = 1'b0,
    PERF_BUSY = 1'b1
  } perf_chan_state_t;

endpackage : perf_pkg

// File: rtl/perf_channel.sv
// One memory handshake channel: request FSM plus access and cycle counters.
module perf_channel
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 resp,
  input  logic                 count_en,
  input  logic                 clr_acc,
  input  logic                 clr_cyc,
  output logic [CNT_WIDTH-1:0] access,
  output logic [CNT_WIDTH-1:0] cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  perf_chan_state_t state;
  perf_chan_state_t state_nxt;
  logic             acc_inc_c;

  // Increment with optional stick-at-max.
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
    if (SATURATE && (v == CNT_MAX)) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PERF_IDLE;
    else     state <= state_nxt;
  end

  // Next state; an access completes on req&resp, a dropped req aborts.
  always_comb begin
    state_nxt = state;
    acc_inc_c = 1'b0;
    unique case (state)
      PERF_IDLE: begin
        if (req) begin
          if (resp) acc_inc_c = 1'b1;
          else      state_nxt = PERF_BUSY;
        end
      end
      PERF_BUSY: begin
        if (!req) begin
          state_nxt = PERF_IDLE;
        end else if (resp) begin
          acc_inc_c = 1'b1;
          state_nxt = PERF_IDLE;
        end
      end
      default: state_nxt = PERF_IDLE;
    endcase
  end

  // Completed-access counter; clear overrides increment and ignores enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        access <= '0;
    else if (clr_acc)               access <= '0;
    else if (count_en && acc_inc_c) access <= bump(access);
  end

  // Cycles-with-request counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cycles <= '0;
    else if (clr_cyc)         cycles <= '0;
    else if (count_en && req) cycles <= bump(cycles);
  end

endmodule : perf_channel

// File: rtl/perf_counters.sv
// Eight performance counters for the MEM-stage counter window.
module perf_counters
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = PERF_CNT_W,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  count_en,
  input  logic                  instr_req,
  input  logic                  instr_resp,
  input  logic                  data_req,
  input  logic                  data_resp,
  input  logic                  l1_req,
  input  logic                  l1_resp,
  input  logic                  br_resolve,
  input  logic                  br_correct,
  input  logic                  clr_we,
  input  logic [PERF_IDX_W-1:0] clr_idx,
  output logic [CNT_WIDTH-1:0]  num_instr_access,
  output logic [CNT_WIDTH-1:0]  num_data_access,
  output logic [CNT_WIDTH-1:0]  num_l1_access,
  output logic [CNT_WIDTH-1:0]  instr_cycles,
  output logic [CNT_WIDTH-1:0]  data_cycles,
  output logic [CNT_WIDTH-1:0]  l1_cycles,
  output logic [CNT_WIDTH-1:0]  num_predictions,
  output logic [CNT_WIDTH-1:0]  num_correct
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PERF_NUM_CNT-1:0] clr_sel_c;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
    if (SATURATE && (v == CNT_MAX)) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  // One-hot clear select decoded from the window store.
  always_comb begin
    clr_sel_c = '0;
    if (clr_we) clr_sel_c = PERF_NUM_CNT'(1) << clr_idx;
  end

  perf_channel #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(SATURATE)) u_instr (
    .clk      (clk),
    .rst      (rst),
    .req      (instr_req),
    .resp     (instr_resp),
    .count_en (count_en),
    .clr_acc  (clr_sel_c[PERF_IDX_NUM_INSTR_ACCESS]),
    .clr_cyc  (clr_sel_c[PERF_IDX_INSTR_CYCLES]),
    .access   (num_instr_access),
    .cycles   (instr_cycles)
  );

  perf_channel #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(SATURATE)) u_data (
    .clk      (clk),
    .rst      (rst),
    .req      (data_req),
    .resp     (data_resp),
    .count_en (count_en),
    .clr_acc  (clr_sel_c[PERF_IDX_NUM_DATA_ACCESS]),
    .clr_cyc  (clr_sel_c[PERF_IDX_DATA_CYCLES]),
    .access   (num_data_access),
    .cycles   (data_cycles)
  );

  perf_channel #(.CNT_WIDTH(CNT_WIDTH), .SATURATE(SATURATE)) u_l1 (
    .clk      (clk),
    .rst      (rst),
    .req      (l1_req),
    .resp     (l1_resp),
    .count_en (count_en),
    .clr_acc  (clr_sel_c[PERF_IDX_NUM_L1_ACCESS]),
    .clr_cyc  (clr_sel_c[PERF_IDX_L1_CYCLES]),
    .access   (num_l1_access),
    .cycles   (l1_cycles)
  );

  // Resolved-branch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   num_predictions <= '0;
    else if (clr_sel_c[PERF_IDX_NUM_PREDICTIONS]) num_predictions <= '0;
    else if (count_en && br_resolve)           num_predictions <= bump(num_predictions);
  end

  // Correct-prediction counter; br_correct only meaningful with br_resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       num_correct <= '0;
    else if (clr_sel_c[PERF_IDX_NUM_CORRECT])      num_correct <= '0;
    else if (count_en && br_resolve && br_correct) num_correct <= bump(num_correct);
  end

endmodule : perf_counters

// File: tb/tb_perf_counters.sv
// Scoreboard bench for perf_counters plus narrow channels for saturate/wrap.
module tb_perf_counters;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_en;
  logic        instr_req, instr_resp, data_req, data_resp, l1_req, l1_resp;
  logic        br_resolve, br_correct, clr_we;
  logic [2:0]  clr_idx;
  logic [31:0] num_instr_access, num_data_access, num_l1_access;
  logic [31:0] instr_cycles, data_cycles, l1_cycles, num_predictions, num_correct;
  logic        s_req, s_resp;
  logic [3:0]  sat_acc, sat_cyc, wrap_acc, wrap_cyc;

  always #5 clk = ~clk;

  perf_counters dut (
    .clk              (clk),
    .rst              (rst),
    .count_en         (count_en),
    .instr_req        (instr_req),
    .instr_resp       (instr_resp),
    .data_req         (data_req),
    .data_resp        (data_resp),
    .l1_req           (l1_req),
    .l1_resp          (l1_resp),
    .br_resolve       (br_resolve),
    .br_correct       (br_correct),
    .clr_we           (clr_we),
    .clr_idx          (clr_idx),
    .num_instr_access (num_instr_access),
    .num_data_access  (num_data_access),
    .num_l1_access    (num_l1_access),
    .instr_cycles     (instr_cycles),
    .data_cycles      (data_cycles),
    .l1_cycles        (l1_cycles),
    .num_predictions  (num_predictions),
    .num_correct      (num_correct)
  );

  perf_channel #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk (clk), .rst (rst), .req (s_req), .resp (s_resp), .count_en (1'b1),
    .clr_acc (1'b0), .clr_cyc (1'b0), .access (sat_acc), .cycles (sat_cyc)
  );

  perf_channel #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk (clk), .rst (rst), .req (s_req), .resp (s_resp), .count_en (1'b1),
    .clr_acc (1'b0), .clr_cyc (1'b0), .access (wrap_acc), .cycles (wrap_cyc)
  );

  typedef enum {K_TOP, K_STATE, K_SAT} kind_t;
  typedef struct {
    string             name;
    kind_t             kind;
    logic [7:0][31:0]  cnt;
    perf_chan_state_t  st;
    logic [3:0]        sat_c, sat_a, wrap_c, wrap_a;
  } exp_t;

  exp_t             sb_q[$];
  logic [7:0][31:0] exp_cnt;
  logic [7:0][31:0] act;
  int               checks = 0;
  int               failures = 0;
  string            cnt_name[8] = '{"num_instr_access", "num_data_access", "num_l1_access",
                                    "instr_cycles", "data_cycles", "l1_cycles",
                                    "num_predictions", "num_correct"};

  assign act = {num_correct, num_predictions, l1_cycles, data_cycles,
                instr_cycles, num_l1_access, num_data_access, num_instr_access};

  task automatic cmp(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, a, e);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge clk) begin
    exp_t r;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      case (r.kind)
        K_TOP:
          for (int i = 0; i < 8; i++)
            cmp($sformatf("%s.%s", r.name, cnt_name[i]), act[i], r.cnt[i]);
        K_STATE:
          cmp($sformatf("%s.l1_state", r.name), 32'(dut.u_l1.state), 32'(r.st));
        default: begin
          cmp($sformatf("%s.sat_cycles", r.name), 32'(sat_cyc), 32'(r.sat_c));
          cmp($sformatf("%s.sat_access", r.name), 32'(sat_acc), 32'(r.sat_a));
          cmp($sformatf("%s.wrap_cycles", r.name), 32'(wrap_cyc), 32'(r.wrap_c));
          cmp($sformatf("%s.wrap_access", r.name), 32'(wrap_acc), 32'(r.wrap_a));
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_top(input string name);
    exp_t r;
    r.name = name; r.kind = K_TOP; r.cnt = exp_cnt; r.st = PERF_IDLE;
    r.sat_c = '0; r.sat_a = '0; r.wrap_c = '0; r.wrap_a = '0;
    sb_q.push_back(r);
  endtask

  task automatic push_state(input string name, input perf_chan_state_t st);
    exp_t r;
    r.name = name; r.kind = K_STATE; r.cnt = '0; r.st = st;
    r.sat_c = '0; r.sat_a = '0; r.wrap_c = '0; r.wrap_a = '0;
    sb_q.push_back(r);
  endtask

  task automatic push_sat(input string name, input logic [3:0] sc, input logic [3:0] sa,
                          input logic [3:0] wc, input logic [3:0] wa);
    exp_t r;
    r.name = name; r.kind = K_SAT; r.cnt = '0; r.st = PERF_IDLE;
    r.sat_c = sc; r.sat_a = sa; r.wrap_c = wc; r.wrap_a = wa;
    sb_q.push_back(r);
  endtask

  int rv[6] = '{1, 1, 1, 0, 1, 1};
  int cv[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    rst = 1'b1; count_en = 1'b1;
    instr_req = 0; instr_resp = 0; data_req = 0; data_resp = 0;
    l1_req = 0; l1_resp = 0; br_resolve = 0; br_correct = 0;
    clr_we = 0; clr_idx = '0; s_req = 0; s_resp = 0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_top("reset");

    // Instruction request held 4 cycles, response in cycle 4.
    instr_req = 1; tick(); tick(); tick();
    instr_resp = 1; tick();
    instr_req = 0; instr_resp = 0;
    exp_cnt[0] = 32'd1; exp_cnt[3] = 32'd4;
    push_top("instr_4cyc");

    // Three back-to-back single-cycle data hits.
    data_req = 1; data_resp = 1;
    repeat (3) tick();
    data_req = 0; data_resp = 0;
    exp_cnt[1] = 32'd3; exp_cnt[4] = 32'd3;
    push_top("data_hits");

    // L1 request aborted after 2 cycles.
    l1_req = 1; tick(); tick();
    push_state("l1_pending", PERF_BUSY);
    l1_req = 0; tick();
    exp_cnt[5] = 32'd2;
    push_top("l1_abort");
    push_state("l1_abort", PERF_IDLE);

    // Branch resolutions; one br_correct without resolve.
    for (int i = 0; i < 6; i++) begin
      br_resolve = rv[i][0]; br_correct = cv[i][0];
      tick();
    end
    br_resolve = 0; br_correct = 0;
    exp_cnt[6] = 32'd5; exp_cnt[7] = 32'd3;
    push_top("branches");

    // Clear instr_cycles at 7 while the request is still high.
    instr_req = 1; repeat (3) tick();
    exp_cnt[3] = 32'd7;
    push_top("instr_cyc7");
    clr_we = 1; clr_idx = 3'd3; tick();
    clr_we = 0;
    exp_cnt[3] = 32'd0;
    push_top("clear_wins");
    tick();
    exp_cnt[3] = 32'd1;
    push_top("after_clear");
    instr_resp = 1; tick();
    instr_req = 0; instr_resp = 0;
    exp_cnt[3] = 32'd2; exp_cnt[0] = 32'd2;
    push_top("instr_done");

    // Disabled counting: clear still acts, FSM still tracks.
    count_en = 0; instr_req = 1; br_resolve = 1; br_correct = 1;
    clr_we = 1; clr_idx = 3'd6; tick();
    clr_we = 0;
    exp_cnt[6] = 32'd0;
    push_top("clear_while_disabled");
    tick();
    push_top("frozen");
    count_en = 1; instr_resp = 1; br_resolve = 0; br_correct = 0; tick();
    instr_req = 0; instr_resp = 0;
    exp_cnt[3] = 32'd3; exp_cnt[0] = 32'd3;
    push_top("complete_across_enable");

    // Read in the clear cycle sees the pre-clear value.
    clr_we = 1; clr_idx = 3'd0;
    push_top("read_in_clear_cycle");
    tick();
    clr_we = 0;
    exp_cnt[0] = 32'd0;
    push_top("read_after_clear");

    // Asynchronous reset while the instruction channel is busy.
    instr_req = 1; tick();
    exp_cnt[3] = 32'd4;
    push_top("pre_reset");
    tick();
    rst = 1'b1;
    exp_cnt = '0;
    push_top("async_reset");
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    exp_cnt[3] = 32'd1;
    push_top("req_after_reset");
    instr_req = 0;

    // Narrow channels: run up to max-1, then past the top.
    s_req = 1; s_resp = 1;
    repeat (14) tick();
    push_sat("narrow_14", 4'hE, 4'hE, 4'hE, 4'hE);
    repeat (3) tick();
    push_sat("narrow_17", 4'hF, 4'hF, 4'h1, 4'h1);
    s_req = 0; s_resp = 0;

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_perf_counters
